capture_buffer_ctrl: RTL

CAPTURE_BUFFER_CTRL -- requirements
Module: capture_buffer_ctrl

---
 rtl/capture_buffer_ctrl_if.sv | 35 +++
 rtl/capture_buffer_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/capture_buffer_ctrl_if.sv
// Capture buffer control bus: sample input, frame/control
// inputs, display read port and status outputs.
interface capture_buffer_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 14
);
  logic                     sample_valid;
  logic [NUM_CH*DATA_W-1:0] sample_data;
  logic                     frame_sync;
  logic                     pause;
  logic [1:0]               mode;
  logic                     arm;
  logic [DATA_W-1:0]        trig_level;
  logic [ADDR_W-1:0]        rd_addr;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic                     disp_bank;
  logic [1:0]               state;
  logic                     capture_done;
  logic                     overrun;

  modport master (
    output sample_valid, sample_data, frame_sync,
    output pause, mode, arm, trig_level, rd_addr,
    input  rd_data, disp_bank, state,
    input  capture_done, overrun
  );

  modport slave (
    input  sample_valid, sample_data, frame_sync,
    input  pause, mode, arm, trig_level, rd_addr,
    output rd_data, disp_bank, state,
    output capture_done, overrun
  );
endinterface

// File: rtl/capture_buffer_ctrl.sv
// Ping-pong ADC capture buffer: one bank fills while the
// other is displayed; banks swap on frame_sync once full.
module capture_buffer_ctrl #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 15360,
  parameter int ADDR_W = 14
) (
  input logic clk,
  input logic Reset,
  capture_buffer_ctrl_if.slave bus
);
  localparam int W     = NUM_CH * DATA_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FILL  = 2'd2,
    FULL  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               disp_bank_q, disp_bank_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  prev_ch0_q, prev_ch0_d;
  logic               first_q, first_d;
  logic               capture_done_q, capture_done_d;
  logic               overrun_q, overrun_d;
  logic               rd_ok_q, rd_ok_d;
  logic               rd_sel_q, rd_sel_d;

  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic [DATA_W-1:0]  ch0;
  logic               is_last;
  logic               trig_hit;
  logic [ADDR_W-1:0]  one;

  logic [W-1:0]       bank0 [DEPTH];
  logic [W-1:0]       bank1 [DEPTH];
  logic [W-1:0]       rd0_q;
  logic [W-1:0]       rd1_q;
  logic [IDX_W-1:0]   widx;
  logic [IDX_W-1:0]   ridx;

  assign one      = {{(ADDR_W-1){1'b0}}, 1'b1};
  assign ch0      = bus.sample_data[DATA_W-1:0];
  assign is_last  = (32'(wr_addr_q) == 32'(DEPTH - 1));
  assign trig_hit = !first_q
                 && (prev_ch0_q < bus.trig_level)
                 && (ch0 >= bus.trig_level);
  assign widx     = waddr[IDX_W-1:0];
  assign ridx     = bus.rd_addr[IDX_W-1:0];

  // Next-state, write strobe and status updates.
  always_comb begin
    state_d        = state_q;
    disp_bank_d    = disp_bank_q;
    wr_addr_d      = wr_addr_q;
    prev_ch0_d     = prev_ch0_q;
    first_d        = first_q;
    capture_done_d = 1'b0;
    overrun_d      = overrun_q;
    we             = 1'b0;
    waddr          = wr_addr_q;
    unique case (state_q)
      IDLE: begin
        wr_addr_d = '0;
        first_d   = 1'b1;
        if (!bus.pause) begin
          if (bus.mode == 2'd0) begin
            state_d = FILL;
          end else if (bus.mode == 2'd2) begin
            if (bus.arm) state_d = ARMED;
          end else begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (bus.pause) begin
          state_d   = IDLE;
          wr_addr_d = '0;
        end else if (bus.sample_valid) begin
          prev_ch0_d = ch0;
          first_d    = 1'b0;
          if (trig_hit) begin
            we        = 1'b1;
            waddr     = '0;
            wr_addr_d = one;
            state_d   = FILL;
          end
        end
      end
      FILL: begin
        if (bus.pause) begin
          state_d   = IDLE;
          wr_addr_d = '0;
        end else if (bus.sample_valid) begin
          we = 1'b1;
          if (is_last) begin
            wr_addr_d      = '0;
            state_d        = FULL;
            capture_done_d = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + one;
          end
        end
      end
      FULL: begin
        if (bus.frame_sync && !bus.pause) begin
          disp_bank_d = ~disp_bank_q;
          overrun_d   = 1'b0;
          state_d     = IDLE;
        end else if (bus.sample_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read qualification: out-of-range addresses return zero.
  always_comb begin
    rd_ok_d  = (32'(bus.rd_addr) < 32'(DEPTH));
    rd_sel_d = disp_bank_q;
  end

  // Control state register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= IDLE;
      disp_bank_q    <= 1'b0;
      wr_addr_q      <= '0;
      prev_ch0_q     <= '0;
      first_q        <= 1'b1;
      capture_done_q <= 1'b0;
      overrun_q      <= 1'b0;
      rd_ok_q        <= 1'b0;
      rd_sel_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      disp_bank_q    <= disp_bank_d;
      wr_addr_q      <= wr_addr_d;
      prev_ch0_q     <= prev_ch0_d;
      first_q        <= first_d;
      capture_done_q <= capture_done_d;
      overrun_q      <= overrun_d;
      rd_ok_q        <= rd_ok_d;
      rd_sel_q       <= rd_sel_d;
    end
  end

  // Bank 0: written only while bank 1 is displayed.
  always_ff @(posedge clk) begin
    if (we && disp_bank_q) bank0[widx] <= bus.sample_data;
    if (rd_ok_d && !disp_bank_q) rd0_q <= bank0[ridx];
  end

  // Bank 1: written only while bank 0 is displayed.
  always_ff @(posedge clk) begin
    if (we && !disp_bank_q) bank1[widx] <= bus.sample_data;
    if (rd_ok_d && disp_bank_q) rd1_q <= bank1[ridx];
  end

  assign bus.rd_data      = !rd_ok_q ? '0 :
                            (rd_sel_q ? rd1_q : rd0_q);
  assign bus.disp_bank    = disp_bank_q;
  assign bus.state        = state_q;
  assign bus.capture_done = capture_done_q;
  assign bus.overrun      = overrun_q;
endmodule
